// File: rtl/mc_cpu_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and its datapath and memories.
interface mc_cpu_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       i_opcode;
  logic [2:0]       i_funct3;
  logic [6:0]       i_funct7;
  logic             i_inst_valid;
  logic             i_d_valid;
  logic             i_alu_ovf;
  logic             i_br_taken;
  logic             i_addr_err;
  logic             o_imem_req;
  logic             o_ir_en;
  logic             o_reg_a_en;
  logic             o_reg_b_en;
  logic             o_alu_out_en;
  logic             o_dmem_req;
  logic             o_dmem_we;
  logic             o_mdr_en;
  logic             o_rf_we;
  logic             o_pc_en;
  logic             o_pc_sel;
  logic [2:0]       o_status;
  logic             o_status_valid;
  logic             o_halt;
  logic [CNT_W-1:0] o_inst_cnt;

  // The controller is the master; the datapath/memory side is the slave.
  modport master (
    input  i_opcode, i_funct3, i_funct7, i_inst_valid, i_d_valid,
           i_alu_ovf, i_br_taken, i_addr_err,
    output o_imem_req, o_ir_en, o_reg_a_en, o_reg_b_en, o_alu_out_en,
           o_dmem_req, o_dmem_we, o_mdr_en, o_rf_we, o_pc_en, o_pc_sel,
           o_status, o_status_valid, o_halt, o_inst_cnt
  );
  modport slave (
    output i_opcode, i_funct3, i_funct7, i_inst_valid, i_d_valid,
           i_alu_ovf, i_br_taken, i_addr_err,
    input  o_imem_req, o_ir_en, o_reg_a_en, o_reg_b_en, o_alu_out_en,
           o_dmem_req, o_dmem_we, o_mdr_en, o_rf_we, o_pc_en, o_pc_sel,
           o_status, o_status_valid, o_halt, o_inst_cnt
  );
endinterface

// File: rtl/mc_cpu_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// per-instruction status strobe, retired count, and sticky halt on EOF/invalid/timeout.
module mc_cpu_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mc_cpu_ctrl_if.master  bus
);
  localparam int WCNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT);

  localparam logic [2:0] ST_R = 3'd0, ST_I = 3'd1, ST_S = 3'd2, ST_B = 3'd3,
                         ST_U = 3'd4, ST_INV = 3'd5, ST_EOF = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_IF, S_IF_WAIT, S_ID, S_EX, S_MEM, S_MEM_WAIT, S_WB, S_PC, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [2:0]        cls_q, dec_cls, halt_status;
  logic              addsub_q, load_q, store_q;
  logic              dec_addsub, dec_load, dec_store;
  logic              pc_sel_q, status_valid_q, halt_q;
  logic [2:0]        status_q;
  logic [CNT_W-1:0]  cnt_q;
  logic imem_req, ir_en, reg_ab_en, alu_out_en, dmem_req, dmem_we, mdr_en, rf_we, pc_en;

  always_comb begin
    dec_cls    = ST_INV;
    dec_addsub = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    case (bus.i_opcode)
      7'b0110011: begin
        case ({bus.i_funct7, bus.i_funct3})
          {7'b0000000, 3'b000}, {7'b0100000, 3'b000}: begin
            dec_cls    = ST_R;
            dec_addsub = 1'b1;
          end
          {7'b0000000, 3'b010}, {7'b0000000, 3'b001}, {7'b0000000, 3'b101}: dec_cls = ST_R;
          default: ;
        endcase
      end
      7'b0010011: begin
        if (bus.i_funct3 == 3'b000) begin
          dec_cls    = ST_I;
          dec_addsub = 1'b1;
        end else if (bus.i_funct3 == 3'b010) begin
          dec_cls = ST_I;
        end
      end
      7'b0000011: if (bus.i_funct3 == 3'b010) begin
        dec_cls  = ST_I;
        dec_load = 1'b1;
      end
      7'b0100011: if (bus.i_funct3 == 3'b010) begin
        dec_cls   = ST_S;
        dec_store = 1'b1;
      end
      7'b1100011: begin
        case (bus.i_funct3)
          3'b000, 3'b001, 3'b100, 3'b101: dec_cls = ST_B;
          default: ;
        endcase
      end
      7'b0010111: dec_cls = ST_U;
      7'b1110011: dec_cls = ST_EOF;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    halt_status = ST_INV;
    imem_req    = 1'b0;
    ir_en       = 1'b0;
    reg_ab_en   = 1'b0;
    alu_out_en  = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    mdr_en      = 1'b0;
    rf_we       = 1'b0;
    pc_en       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_IF;
      S_IF: begin
        imem_req = 1'b1;
        wcnt_d   = '0;
        state_d  = S_IF_WAIT;
      end
      // Valid on the cycle the count sits at MAX_WAIT is still accepted.
      S_IF_WAIT: begin
        if (bus.i_inst_valid) begin
          ir_en   = 1'b1;
          state_d = S_ID;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = S_HALT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_ID: begin
        reg_ab_en = 1'b1;
        if (dec_cls == ST_EOF) begin
          halt_status = ST_EOF;
          state_d     = S_HALT;
        end else if (dec_cls == ST_INV) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_out_en = 1'b1;
        if (addsub_q && bus.i_alu_ovf) state_d = S_HALT;
        else if (load_q || store_q)    state_d = S_MEM;
        else if (cls_q == ST_B)        state_d = S_PC;
        else                           state_d = S_WB;
      end
      S_MEM: begin
        if (bus.i_addr_err) begin
          state_d = S_HALT;
        end else begin
          dmem_req = 1'b1;
          dmem_we  = store_q;
          wcnt_d   = '0;
          state_d  = store_q ? S_PC : S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (bus.i_d_valid) begin
          mdr_en  = 1'b1;
          state_d = S_WB;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = S_HALT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_PC;
      end
      S_PC: begin
        pc_en   = 1'b1;
        state_d = S_IF;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= S_IDLE;
      wcnt_q         <= '0;
      cls_q          <= ST_R;
      addsub_q       <= 1'b0;
      load_q         <= 1'b0;
      store_q        <= 1'b0;
      pc_sel_q       <= 1'b0;
      status_q       <= 3'd0;
      status_valid_q <= 1'b0;
      halt_q         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      status_valid_q <= 1'b0;
      halt_q         <= (state_d == S_HALT);
      if (state_q == S_ID) begin
        cls_q    <= dec_cls;
        addsub_q <= dec_addsub;
        load_q   <= dec_load;
        store_q  <= dec_store;
      end
      if (state_q == S_EX) pc_sel_q <= (cls_q == ST_B) && bus.i_br_taken;
      // Exactly one strobe per retired instruction or per halt entry.
      if (state_q == S_PC) begin
        status_q       <= cls_q;
        status_valid_q <= 1'b1;
        cnt_q          <= cnt_q + 1'b1;
      end else if (state_d == S_HALT && state_q != S_HALT) begin
        status_q       <= halt_status;
        status_valid_q <= 1'b1;
      end
    end
  end

  assign bus.o_imem_req     = imem_req;
  assign bus.o_ir_en        = ir_en;
  assign bus.o_reg_a_en     = reg_ab_en;
  assign bus.o_reg_b_en     = reg_ab_en;
  assign bus.o_alu_out_en   = alu_out_en;
  assign bus.o_dmem_req     = dmem_req;
  assign bus.o_dmem_we      = dmem_we;
  assign bus.o_mdr_en       = mdr_en;
  assign bus.o_rf_we        = rf_we;
  assign bus.o_pc_en        = pc_en;
  assign bus.o_pc_sel       = pc_sel_q;
  assign bus.o_status       = status_q;
  assign bus.o_status_valid = status_valid_q;
  assign bus.o_halt         = halt_q;
  assign bus.o_inst_cnt     = cnt_q;
endmodule
